// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, muldiv op encoding and FSM states.
package alu_pkg;
    localparam int XLEN = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;
endpackage

// File: rtl/magnitude_muldiv_if.sv
// Request/response bundle between the ALU sign-inversion stage and the muldiv unit.
interface magnitude_muldiv_if #(parameter int WIDTH = alu_pkg::XLEN);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_a;
    logic             neg_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    modport master (
        output start, op, mag_a, mag_b, neg_a, neg_b,
        input  busy, done, result, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, mag_a, mag_b, neg_a, neg_b,
        output busy, done, result, result_hi, div_by_zero
    );
endinterface

// File: rtl/sign_restore.sv
// Conditional two's-complement negator, modulo 2^W.
module sign_restore #(
    parameter int W = 16
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);
    assign val_o = neg_i ? (W'(0) - val_i) : val_i;
endmodule

// File: rtl/magnitude_muldiv.sv
// Iterative unsigned shift-add multiply / restoring divide with sign restore.
// Divide datapath is compiled in only when ALU_DIV_EN is defined.
module magnitude_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    magnitude_muldiv_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand for MUL, divisor for DIV
    logic             na_q, na_d;
    logic             nb_q, nb_d;
    logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier bits / dividend->quotient
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;

    // Shift-add step: add multiplicand when the low multiplier bit is set, shift right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

    logic [2*WIDTH-1:0] prod_fix;
    sign_restore #(.W(2*WIDTH)) u_prod_sign (
        .val_i ({hi_q, lo_q}),
        .neg_i (na_q ^ nb_q),
        .val_o (prod_fix)
    );

`ifdef ALU_DIV_EN
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_qbit;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_qbit  = ~div_diff[WIDTH];
    assign div_hi_n  = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_n  = {lo_q[WIDTH-2:0], div_qbit};

    sign_restore #(.W(WIDTH)) u_quot_sign (
        .val_i (lo_q),
        .neg_i (na_q ^ nb_q),
        .val_o (quot_fix)
    );

    // Truncating division: remainder follows the dividend's sign.
    sign_restore #(.W(WIDTH)) u_rem_sign (
        .val_i (hi_q),
        .neg_i (na_q),
        .val_o (rem_fix)
    );
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        na_d        = na_q;
        nb_d        = nb_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
`ifdef ALU_DIV_EN
        dbz_d       = dbz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    opnd_d  = (bus.op == OP_DIV) ? bus.mag_b : bus.mag_a;
                    lo_d    = (bus.op == OP_DIV) ? bus.mag_a : bus.mag_b;
                    hi_d    = '0;
                    na_d    = bus.neg_a;
                    nb_d    = bus.neg_b;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
`ifdef ALU_DIV_EN
                if (op_q == OP_DIV) begin
                    hi_d = div_hi_n;
                    lo_d = div_lo_n;
                end else
`endif
                begin
                    hi_d = mul_hi_n;
                    lo_d = mul_lo_n;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q == OP_MUL) begin
                    result_d    = prod_fix[WIDTH-1:0];
                    result_hi_d = prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
                    dbz_d       = 1'b0;
                end else begin
                    // A zero divisor leaves quotient all ones and remainder = dividend.
                    dbz_d       = (opnd_q == '0);
                    result_d    = (opnd_q == '0) ? '1 : quot_fix;
                    result_hi_d = rem_fix;
`else
                end else begin
                    result_d    = '0;
                    result_hi_d = '0;
`endif
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            opnd_q      <= '0;
            na_q        <= 1'b0;
            nb_q        <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            na_q        <= na_d;
            nb_q        <= nb_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
        end
    end

`ifdef ALU_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dbz_q <= 1'b0;
        else     dbz_q <= dbz_d;
    end
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
endmodule
